// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, register-address and
// word typedefs, and the hard-wired zero register index.
// No ports.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;

    typedef logic [CPU_ADDR_W-1:0] reg_addr_t;
    typedef logic [CPU_DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-write counter for one architectural register.
// Counts issued-but-not-retired writes. The owner gates inc with
// "not saturated", so the counter never wraps upward.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   inc         accepted issue targeting this register
//   dec_req     writeback targeting this register (retire attempt)
//   count       current number of outstanding writes
//   err         retire attempt with nothing outstanding and no same-cycle issue
module regfile_sb_cnt #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec_req,
    output logic [PEND_W-1:0] count,
    output logic              err
);

    logic dec;

    // A retire only counts when something is outstanding; an empty-counter
    // retire leaves the count alone and is flagged, unless an issue to the
    // same register lands in the same cycle (which then just increments).
    assign dec = dec_req && (count != '0);
    assign err = dec_req && (count == '0) && !inc;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && !dec)
            count <= count + 1'b1;
        else if (dec && !inc)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with a per-register pending-write
// scoreboard. Decode reads operands and issues destinations; writeback
// writes data and retires one pending write per strobe.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   rd_addr     NREAD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data     NREAD packed read data, combinational
//   rd_busy     per port: addressed register has outstanding writes
//   iss_valid   decode issues an instruction writing iss_addr
//   iss_addr    destination of the issued instruction
//   iss_ready   0 when iss_addr's counter is saturated
//   we, wa, wd  writeback strobe / address / data (also retires one pending)
//   wpc         PC of the writing instruction, used only by the trace
//   sb_err      sticky scoreboard error, cleared by reset
// Build option: define REGFILE_WB_BYPASS_EN to forward same-cycle write
// data to readers and mask rd_busy when that write retires the last
// outstanding entry.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int NREAD  = 2,
    parameter int PEND_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    output logic                    iss_ready,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [31:0]             wpc,
    output logic                    sb_err
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DATA_W-1:0]             mem [DEPTH];
    logic [DEPTH-1:0][PEND_W-1:0]  pend;
    logic [DEPTH-1:0]              cnt_err;
    logic                          wr_en;
    logic                          iss_ok;
    logic                          iss_err;

    assign wr_en     = we && (wa != '0);
    assign iss_ready = (iss_addr == '0) || (pend[iss_addr] != PEND_MAX);
    assign iss_ok    = iss_valid && iss_ready;
    assign iss_err   = iss_valid && !iss_ready;

    // r0 has no counter: never busy, never errors.
    assign pend[0]    = '0;
    assign cnt_err[0] = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_cnt
        regfile_sb_cnt #(.PEND_W(PEND_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (iss_ok && (iss_addr == ADDR_W'(r))),
            .dec_req (we && (wa == ADDR_W'(r))),
            .count   (pend[r]),
            .err     (cnt_err[r])
        );
    end

    // Data lands even when the retire itself is flagged as an error.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            sb_err <= 1'b0;
        else if ((|cnt_err) || iss_err)
            sb_err <= 1'b1;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Same-cycle issue to the written register keeps the count unchanged,
    // so only a plain retire from 1 can clear busy early.
    logic wa_inc;
    assign wa_inc = iss_ok && (iss_addr == wa);
`endif

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
        assign rv = (ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_WB_BYPASS_EN
        logic fwd;
        assign fwd = wr_en && (wa == ra);
        assign rd_data[i*DATA_W +: DATA_W] = fwd ? wd : rv;
        assign rd_busy[i] = (pend[ra] != '0) &&
                            !(fwd && (pend[ra] == PEND_W'(1)) && !wa_inc);
`else
        assign rd_data[i*DATA_W +: DATA_W] = rv;
        assign rd_busy[i] = (pend[ra] != '0);
`endif
    end

`ifndef SYNTHESIS
    // Write trace for simulation logs.
    always_ff @(posedge clk) begin
        if (!reset && wr_en)
            $display("@%h: $%d <= %h", wpc, wa, wd);
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int PW = 2;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             iss_ready;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [31:0]      wpc;
    logic             sb_err;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .PEND_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .wpc       (wpc),
        .sb_err    (sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] data;
        logic [1:0]  busy;
        logic        ready;
        logic        err;
    } vec_t;

    vec_t exp_q[$];
    vec_t obs_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_addr = '0;
        we = 1'b0; wa = '0; wd = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic [63:0] d,
                            input logic [1:0] b, input logic r, input logic e);
        vec_t v;
        v.tag = tag; v.data = d; v.busy = b; v.ready = r; v.err = e;
        exp_q.push_back(v);
    endtask

    task automatic snap();
        vec_t v;
        #2;
        v.tag = ""; v.data = rd_data; v.busy = rd_busy;
        v.ready = iss_ready; v.err = sb_err;
        obs_q.push_back(v);
    endtask

    task automatic test_reset();
        vec_t e, o;
        do_reset();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {AW'(a), AW'(a)}; iss_addr = AW'(a);
            push_exp($sformatf("reset_r%0d", a), 64'h0, 2'b00, 1'b1, 1'b0);
            snap();
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    task automatic test_r0_write();
        vec_t e, o;
        idle(); we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF; wpc = 32'h100; rd_addr = {5'd0, 5'd0};
        push_exp("r0_wr_pre", 64'h0, 2'b00, 1'b1, 1'b0); snap(); cyc();
        idle(); rd_addr = {5'd0, 5'd0};
        push_exp("r0_wr_post", 64'h0, 2'b00, 1'b1, 1'b0); snap();
        iss_valid = 1'b1; iss_addr = 5'd5; rd_addr = {5'd5, 5'd5};
        push_exp("r5_issue", 64'h0, 2'b00, 1'b1, 1'b0); snap(); cyc();
        idle(); iss_addr = 5'd5; we = 1'b1; wa = 5'd5; wd = 32'h1234; wpc = 32'h104;
        push_exp("r5_wr_same", BYP ? {32'h1234, 32'h1234} : 64'h0,
                 BYP ? 2'b00 : 2'b11, 1'b1, 1'b0);
        snap(); cyc();
        idle();
        push_exp("r5_wr_next", {32'h1234, 32'h1234}, 2'b00, 1'b1, 1'b0); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    task automatic test_pending_r7();
        vec_t e, o;
        idle(); iss_valid = 1'b1; iss_addr = 5'd7; rd_addr = {5'd7, 5'd7};
        cyc(); cyc();
        iss_valid = 1'b0;
        push_exp("r7_two_issued", 64'h0, 2'b11, 1'b1, 1'b0); snap();
        we = 1'b1; wa = 5'd7; wd = 32'h7777_0007; wpc = 32'h200;
        push_exp("r7_retire1_pre", BYP ? {32'h7777_0007, 32'h7777_0007} : 64'h0,
                 2'b11, 1'b1, 1'b0);
        snap(); cyc();
        push_exp("r7_retire2_pre", {32'h7777_0007, 32'h7777_0007},
                 BYP ? 2'b00 : 2'b11, 1'b1, 1'b0);
        snap(); cyc();
        idle(); iss_addr = 5'd7;
        push_exp("r7_drained", {32'h7777_0007, 32'h7777_0007}, 2'b00, 1'b1, 1'b0); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    task automatic test_saturate_r3();
        vec_t e, o;
        idle(); iss_valid = 1'b1; iss_addr = 5'd3; rd_addr = {5'd3, 5'd3};
        cyc(); cyc(); cyc();
        iss_valid = 1'b0;
        push_exp("r3_saturated", 64'h0, 2'b11, 1'b0, 1'b0); snap();
        iss_valid = 1'b1;
        push_exp("r3_forced_pre", 64'h0, 2'b11, 1'b0, 1'b0); snap(); cyc();
        iss_valid = 1'b0;
        push_exp("r3_forced_err", 64'h0, 2'b11, 1'b0, 1'b1); snap();
        we = 1'b1; wa = 5'd3; wd = 32'h33; wpc = 32'h300; cyc();
        we = 1'b0;
        push_exp("r3_one_retired", {32'h33, 32'h33}, 2'b11, 1'b1, 1'b1); snap();
        we = 1'b1; wd = 32'h34; cyc(); cyc();
        idle(); iss_addr = 5'd3;
        push_exp("r3_drained", {32'h34, 32'h34}, 2'b00, 1'b1, 1'b1); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    task automatic test_same_cycle_r9();
        vec_t e, o;
        do_reset();
        iss_valid = 1'b1; iss_addr = 5'd9; rd_addr = {5'd9, 5'd9}; cyc();
        we = 1'b1; wa = 5'd9; wd = 32'h99; wpc = 32'h400;
        push_exp("r9_iss_ret_pre", BYP ? {32'h99, 32'h99} : 64'h0, 2'b11, 1'b1, 1'b0);
        snap(); cyc();
        idle(); iss_addr = 5'd9;
        push_exp("r9_count_held", {32'h99, 32'h99}, 2'b11, 1'b1, 1'b0); snap();
        we = 1'b1; wa = 5'd9; wd = 32'h9A; cyc();
        wd = 32'h9B;
        push_exp("r9_empty_ret_pre", BYP ? {32'h9B, 32'h9B} : {32'h9A, 32'h9A},
                 2'b00, 1'b1, 1'b0);
        snap(); cyc();
        idle(); iss_addr = 5'd9;
        push_exp("r9_empty_ret_err", {32'h9B, 32'h9B}, 2'b00, 1'b1, 1'b1); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    task automatic test_bypass_r4();
        vec_t e, o;
        do_reset();
        iss_valid = 1'b1; iss_addr = 5'd4; cyc();
        idle(); we = 1'b1; wa = 5'd4; wd = 32'hA5A5; wpc = 32'h500; rd_addr = {5'd4, 5'd0};
        push_exp("r4_fwd_same", BYP ? {32'hA5A5, 32'h0} : 64'h0,
                 BYP ? 2'b00 : 2'b10, 1'b1, 1'b0);
        snap(); cyc();
        idle();
        push_exp("r4_fwd_next", {32'hA5A5, 32'h0}, 2'b00, 1'b1, 1'b0); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t e, o;
        idle(); we = 1'b1; wa = 5'd10; wd = 32'h1; wpc = 32'h600; cyc();
        idle(); iss_valid = 1'b1; iss_addr = 5'd6; cyc();
        reset = 1'b1; iss_valid = 1'b1; iss_addr = 5'd6;
        we = 1'b1; wa = 5'd6; wd = 32'h6666; rd_addr = {5'd6, 5'd6};
        push_exp("r6_rst_pre", BYP ? {32'h6666, 32'h6666} : 64'h0, 2'b11, 1'b1, 1'b1);
        snap(); cyc();
        reset = 1'b0; idle(); iss_addr = 5'd6; rd_addr = {5'd10, 5'd6};
        push_exp("r6_rst_post", 64'h0, 2'b00, 1'b1, 1'b0); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    // Issue and write the same register every cycle; port 0 reads the
    // register being written, port 1 the one written the cycle before.
    task automatic test_back_to_back();
        vec_t e, o;
        logic [31:0] model [32];
        bit          pendm [32];
        int          a, prev;
        logic [31:0] d, d0, d1;
        do_reset();
        for (int i = 0; i < 32; i++) begin model[i] = '0; pendm[i] = 1'b0; end
        prev = 0;
        for (int k = 0; k < 12; k++) begin
            a = $urandom_range(1, 31);
            d = $urandom;
            iss_valid = 1'b1; iss_addr = AW'(a);
            we = 1'b1; wa = AW'(a); wd = d; wpc = 32'h700 + 32'(k * 4);
            rd_addr = {AW'(prev), AW'(a)};
            d0 = BYP ? d : model[a];
            d1 = (BYP && prev == a) ? d : model[prev];
            push_exp($sformatf("b2b_%0d_r%0d", k, a), {d1, d0},
                     {pendm[prev], pendm[a]}, 1'b1, 1'b0);
            snap(); cyc();
            model[a] = d; pendm[a] = 1'b1; prev = a;
        end
        idle(); rd_addr = {AW'(prev), AW'(prev)};
        push_exp("b2b_final", {model[prev], model[prev]}, 2'b11, 1'b1, 1'b0); snap();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_err++; $display("FAIL %s: no sample", e.tag);
            end else begin
                o = obs_q.pop_front();
                if ({o.data, o.busy, o.ready, o.err} !== {e.data, e.busy, e.ready, e.err}) begin
                    n_err++;
                    $display("FAIL %s: got data=%h busy=%b ready=%b err=%b, want data=%h busy=%b ready=%b err=%b",
                             e.tag, o.data, o.busy, o.ready, o.err, e.data, e.busy, e.ready, e.err);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rd_addr = '0; wpc = '0;
        idle();
        test_reset();
        test_r0_write();
        test_pending_r7();
        test_saturate_r3();
        test_same_cycle_r9();
        test_bypass_r4();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
